// File: rtl/iiitb_bm_pkg.sv
// Shared types and default sizing for the Booth-multiplier round-robin scheduler.
package iiitb_bm_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int MUL_LAT_DEF = 5;
    localparam int OP_W        = 4;
    localparam int PROD_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        RESP
    } state_t;

endpackage

// File: rtl/iiitb_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first set request at or after
// ptr (wrapping modulo N_REQ) wins.
module iiitb_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    // Requester index examined at each priority position, highest priority first.
    logic [ID_W-1:0] cand_idx [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = ID_W'((int'(ptr) + gi) % N_REQ);
        end
    endgenerate

    // Walk the priority positions and keep the first requester found.
    always_comb begin
        any       = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[cand_idx[k]]) begin
                any       = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
    end

    // Expand the winning index into a one-hot grant.
    always_comb begin
        grant = '0;
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/iiitb_bm_rr_sched.sv
// Round-robin scheduler that time-shares one external Booth multiplier core
// among N_REQ requesters, one job in flight at a time.
module iiitb_bm_rr_sched
    import iiitb_bm_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [OP_W*N_REQ-1:0]   req_m,
    input  logic [OP_W*N_REQ-1:0]   req_q,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [PROD_W-1:0]       rsp_p,
    input  logic                    rsp_ready,
    output logic                    mul_load,
    output logic                    mul_reset,
    output logic [OP_W-1:0]         mul_m,
    output logic [OP_W-1:0]         mul_q,
    input  logic [PROD_W-1:0]       mul_p
);

    // Counter holds MUL_LAT-1 down to 0, so RUN lasts exactly MUL_LAT cycles.
    localparam int LAT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ID_W-1:0]     id_reg;
    logic [LAT_W-1:0]    lat_cnt_reg;
    logic [OP_W-1:0]     mul_m_reg, mul_q_reg;
    logic                rsp_valid_reg;
    logic [ID_W-1:0]     rsp_id_reg;
    logic [PROD_W-1:0]   rsp_p_reg;

    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic [ID_W-1:0]     rr_ptr_next;

    logic [OP_W-1:0]     m_slice [N_REQ];
    logic [OP_W-1:0]     q_slice [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign m_slice[gi] = req_m[OP_W*gi +: OP_W];
            assign q_slice[gi] = req_q[OP_W*gi +: OP_W];
        end
    endgenerate

    iiitb_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Priority restarts just after the requester that was served.
    assign rr_ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign mul_reset = reset;
    assign mul_m     = mul_m_reg;
    assign mul_q     = mul_q_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_p     = rsp_p_reg;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus the accept strobe and core load pulse.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        mul_load   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    req_ready  = grant;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                mul_load   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (lat_cnt_reg == '0) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Nothing is accepted or launched while the block is being reset.
        if (reset) begin
            req_ready = '0;
            mul_load  = 1'b0;
        end
    end

    // Datapath: operand latch, latency counter, product capture and response hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg    <= '0;
            id_reg        <= '0;
            lat_cnt_reg   <= '0;
            mul_m_reg     <= '0;
            mul_q_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_p_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        mul_m_reg  <= m_slice[grant_idx];
                        mul_q_reg  <= q_slice[grant_idx];
                        id_reg     <= grant_idx;
                        rr_ptr_reg <= rr_ptr_next;
                    end
                end
                LOAD: begin
                    lat_cnt_reg <= LAT_W'(MUL_LAT - 1);
                end
                RUN: begin
                    if (lat_cnt_reg != '0) begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                CAPTURE: begin
                    rsp_p_reg     <= mul_p;
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
